// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative HI/LO multiply/divide unit, one bit per cycle
module muldiv #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);
    localparam int W  = WORD_SIZE;
    localparam int CW = $clog2(WORD_SIZE);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opb_q, opb_d;
    logic            neg_prod_q, neg_prod_d;
    logic            neg_rem_q, neg_rem_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            signed_op;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      sum;
    logic [W:0]      shifted;
    logic [W-1:0]    diff;
    logic            ge;
    logic [2*W-1:0]  mul_next, div_next, prod_fix;
    logic [W-1:0]    quot, rem;

    // Operands are converted to magnitudes on entry; signs are reapplied on the final write.
    assign signed_op = ~op[0];
    assign mag_a     = (signed_op && a[W-1]) ? -a : a;
    assign mag_b     = (signed_op && b[W-1]) ? -b : b;

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    assign sum       = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};
    assign mul_next  = acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    assign prod_fix  = neg_prod_q ? -mul_next : mul_next;

    assign shifted   = {acc_q[2*W-1:W], acc_q[W-1]};
    assign ge        = shifted >= {1'b0, opb_q};
    assign diff      = shifted[W-1:0] - opb_q;
    assign div_next  = {(ge ? diff : shifted[W-1:0]), acc_q[W-2:0], ge};
    assign quot      = div_next[W-1:0];
    assign rem       = div_next[2*W-1:W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        neg_prod_d = neg_prod_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001: begin
                            acc_d      = {{W{1'b0}}, mag_a};
                            opb_d      = mag_b;
                            neg_prod_d = signed_op & (a[W-1] ^ b[W-1]);
                            neg_rem_d  = 1'b0;
                            cnt_d      = '0;
                            busy_d     = 1'b1;
                            state_d    = MUL;
                        end
                        3'b010, 3'b011: begin
                            acc_d      = {{W{1'b0}}, mag_a};
                            opb_d      = mag_b;
                            // A zero divisor must yield an all-ones quotient regardless of signs.
                            neg_prod_d = signed_op & (a[W-1] ^ b[W-1]) & (b != '0);
                            neg_rem_d  = signed_op & a[W-1];
                            cnt_d      = '0;
                            busy_d     = 1'b1;
                            state_d    = DIV;
                        end
                        3'b100:  hi_d = a;
                        3'b101:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    {hi_d, lo_d} = prod_fix;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    lo_d    = neg_prod_q ? -quot : quot;
                    hi_d    = neg_rem_q ? -rem : rem;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            neg_prod_q <= neg_prod_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - table-driven bench for muldiv at WORD_SIZE 32
module tb_muldiv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    muldiv #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        logic [31:0] h0, l0;
        int          cyc;
        bit          stable;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op = o; a = xa; b = xb;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 0;
        stable = 1'b1;
        while (busy && cyc < 100) begin
            if (hi !== h0 || lo !== l0 || done) stable = 1'b0;
            start = (cyc == 5);
            op = 3'b100;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({nm, " busy_cycles"}, 64'(cyc), 64'd32);
        check({nm, " done"}, 64'(done), 64'd1);
        check({nm, " hi"}, 64'(hi), 64'(eh));
        check({nm, " lo"}, 64'(lo), 64'(el));
        check({nm, " hold"}, 64'(stable), 64'd1);
        @(negedge clk);
        check({nm, " done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic wait_done(input string nm);
        int cyc;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, " done_wait"}, 64'(done), 64'd1);
    endtask

    initial begin
        logic [31:0] h0, l0;
        bit          saw_done;

        vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'b011, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{3'b001, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
        vecs[8]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[10] = '{3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[11] = '{3'b000, 32'd12345,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7};
        vecs[12] = '{3'b011, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
        vecs[13] = '{3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

        // Abort a MULT at busy cycle 10 with an MTHI attempted mid-flight.
        h0 = hi;
        saw_done = 1'b0;
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            start = (c == 3); op = 3'b100; a = 32'hDEADBEEF;
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        check("abort busy_before", 64'(busy), 64'd1);
        check("abort mthi_ignored", 64'(hi), 64'(h0));
        rst_n = 1'b0;
        @(negedge clk);
        if (done) saw_done = 1'b1;
        check("abort no_done", 64'(saw_done), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        run_op(3'b001, 32'd6, 32'd7, 32'd0, 32'd42, "post_reset");

        // MTLO then MTHI on consecutive cycles.
        start = 1'b1; op = 3'b101; a = 32'h1234;
        @(negedge clk);
        check("mtlo lo", 64'(lo), 64'h1234);
        check("mtlo busy", 64'({busy, done}), 64'd0);
        op = 3'b100; a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        check("mthi hi", 64'(hi), 64'h5678);
        check("mthi lo", 64'(lo), 64'h1234);
        check("mthi busy", 64'({busy, done}), 64'd0);

        // Reserved op leaves everything alone.
        start = 1'b1; op = 3'b110; a = 32'hCAFEF00D;
        @(negedge clk);
        op = 3'b111;
        @(negedge clk);
        start = 1'b0;
        check("rsvd hilo", {hi, lo}, {32'h5678, 32'h1234});
        check("rsvd busy", 64'({busy, done}), 64'd0);

        // Back-to-back: restart in the IDLE cycle after DONE; start held through DONE is ignored.
        run_op(3'b000, 32'd3, 32'd4, 32'd0, 32'd12, "b2b_first");
        start = 1'b1; op = 3'b001; a = 32'd10; b = 32'd10;
        @(negedge clk);
        start = 1'b0;
        check("b2b accept", 64'(busy), 64'd1);
        wait_done("b2b_second");
        check("b2b second lo", 64'(lo), 64'd100);
        start = 1'b1; op = 3'b001; a = 32'd2; b = 32'd3;
        @(negedge clk);
        check("b2b done_ignores_start", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b third accept", 64'(busy), 64'd1);
        wait_done("b2b_third");
        check("b2b third lo", 64'(lo), 64'd6);
        check("b2b third hi", 64'(hi), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
